mips_dmem_responder: RTL and testbench

MIPS_DMEM_RESPONDER -- requirements
Module: mips_dmem_responder

---
 rtl/mips_dmem_responder.sv | 118 +++++++++++
 tb/tb_mips_dmem_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// Wait-state data memory responder for a MIPS datapath: word-addressed RAM behind an IDLE/WAIT/DONE handshake.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses on mem_err and suppress their effects.
module mips_dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALU_result,
  input  logic [31:0] write_mem,
  output logic [31:0] read_mem,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);

  // state | meaning
  // IDLE  | accepting a new request
  // WAIT  | burning wait states on the down-counter
  // DONE  | completing the captured request on the next edge

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic            mis_q, mis_d;
  logic [31:0]     read_mem_q, read_mem_d;
  logic            mem_ready_q, mem_ready_d;
  logic            mem_err_q, mem_err_d;
  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [31:0]     mem_d [DEPTH_WORDS];

  logic unused_addr;
  assign unused_addr = ^ALU_result[31:AW+2];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    mis_d       = mis_q;
    read_mem_d  = read_mem_q;
    mem_ready_d = 1'b0;
    mem_err_d   = 1'b0;
    mem_d       = mem_q;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          idx_d   = ALU_result[AW+1:2];
          wdata_d = write_mem;
          wr_d    = MemWrite;
          mis_d   = TRAP_EN && (ALU_result[1:0] != 2'b00);
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE: begin
        state_d     = IDLE;
        mem_ready_d = 1'b1;
        // A trapped access must leave both memory and read data untouched.
        if (mis_q)     mem_err_d         = 1'b1;
        else if (wr_q) mem_d[idx_q]      = wdata_q;
        else           read_mem_d        = mem_q[idx_q];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      mis_q       <= 1'b0;
      read_mem_q  <= '0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      mis_q       <= mis_d;
      read_mem_q  <= read_mem_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
      mem_q       <= mem_d;
    end
  end

  assign read_mem  = read_mem_q;
  assign mem_ready = mem_ready_q;
  assign mem_err   = TRAP_EN ? mem_err_q : 1'b0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Randomized self-checking bench for mips_dmem_responder against an array-based memory model.
module tb_mips_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WC    = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] ALU_result = '0, write_mem = '0;
  logic [31:0] read_mem;
  logic        mem_ready, mem_err, busy;

  logic        c0_rd = 1'b0, c0_wr = 1'b0;
  logic [31:0] c0_addr = '0, c0_wdata = '0;
  logic [31:0] c0_rdata;
  logic        c0_ready, c0_err, c0_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rd;

  always #5 clk = ~clk;

  mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALU_result(ALU_result), .write_mem(write_mem), .read_mem(read_mem),
    .mem_ready(mem_ready), .mem_err(mem_err), .busy(busy)
  );

  mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .MemRead(c0_rd), .MemWrite(c0_wr),
    .ALU_result(c0_addr), .write_mem(c0_wdata), .read_mem(c0_rdata),
    .mem_ready(c0_ready), .mem_err(c0_err), .busy(c0_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rd = '0;
  endtask

  // Called at #1 after an edge with the DUT idle; leaves at #1 after the edge following mem_ready.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int  idx;
    bit  mis;
    logic exp_err;
    MemRead = rd; MemWrite = wr; ALU_result = addr; write_mem = data;
    @(posedge clk); #1;
    for (int k = 1; k <= WC + 1; k++) begin
      MemRead    = 1'($urandom_range(0, 1));
      MemWrite   = 1'($urandom_range(0, 1));
      ALU_result = $urandom;
      write_mem  = $urandom;
      @(posedge clk); #1;
      if (k <= WC) begin
        chk("ready_early", {31'b0, mem_ready}, 32'd0);
        chk("busy_wait", {31'b0, busy}, 32'd1);
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0; ALU_result = '0; write_mem = '0;
    chk("ready_latency", {31'b0, mem_ready}, 32'd1);
    chk("busy_after", {31'b0, busy}, 32'd0);
    idx = int'((addr >> 2) % DEPTH);
    mis = TRAP && (addr[1:0] != 2'b00);
    exp_err = mis;
    if (!mis) begin
      if (wr) model_mem[idx] = data;
      else    model_rd = model_mem[idx];
    end
    chk("mem_err", {31'b0, mem_err}, {31'b0, exp_err});
    chk("read_mem", read_mem, model_rd);
    @(posedge clk); #1;
    chk("ready_pulse", {31'b0, mem_ready}, 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [1:0]  exp_ready [4];
    logic [1:0]  exp_busy  [4];
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_mem", read_mem, 32'd0);
    chk("rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("rst_err", {31'b0, mem_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;

    // First request lands on the first edge with reset released.
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h10, 32'h0);
    chk("wr_rd_10", read_mem, 32'hDEADBEEF);

    do_req(1'b0, 1'b1, 32'h100, 32'h12345678);
    do_req(1'b1, 1'b0, 32'h000, 32'h0);
    chk("wrap_000", read_mem, 32'h12345678);

    do_req(1'b1, 1'b1, 32'h04, 32'hA5A5A5A5);
    chk("both_hold", read_mem, 32'h12345678);
    do_req(1'b1, 1'b0, 32'h04, 32'h0);
    chk("both_rd_04", read_mem, 32'hA5A5A5A5);

    do_req(1'b0, 1'b1, 32'h0A, 32'hFFFFFFFF);
    do_req(1'b1, 1'b0, 32'h08, 32'h0);
    chk("misalign_rd_08", read_mem, TRAP ? 32'h0 : 32'hFFFFFFFF);

    // Reset one edge into a write: nothing completes and memory is cleared.
    MemWrite = 1'b1; ALU_result = 32'h08; write_mem = 32'h11111111;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      chk("abort_ready", {31'b0, mem_ready}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
    end
    do_req(1'b1, 1'b0, 32'h08, 32'h0);
    chk("abort_rd_08", read_mem, 32'h0);

    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(1, 3));
      a  = {($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'h0, 8'($urandom_range(0, 47))};
      do_req(op[0], op[1], a, $urandom);
    end

    // Zero-wait instance with a write request held across two acceptances.
    exp_ready = '{2'd0, 2'd1, 2'd0, 2'd1};
    exp_busy  = '{2'd1, 2'd0, 2'd1, 2'd0};
    c0_wr = 1'b1; c0_addr = 32'h20; c0_wdata = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("w0_ready", {31'b0, c0_ready}, {31'b0, exp_ready[k][0]});
      chk("w0_busy", {31'b0, c0_busy}, {31'b0, exp_busy[k][0]});
    end
    c0_wr = 1'b0;
    c0_rd = 1'b1;
    @(posedge clk); #1;
    c0_rd = 1'b0;
    chk("w0_rd_busy", {31'b0, c0_busy}, 32'd1);
    @(posedge clk); #1;
    chk("w0_rd_ready", {31'b0, c0_ready}, 32'd1);
    chk("w0_rd_data", c0_rdata, 32'hCAFEF00D);
    chk("w0_err", {31'b0, c0_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
